// File: rtl/sreg_deser.sv
// Parametrised serial-to-parallel deserialiser with a valid/ready holding register and sticky overrun.
// Define SREG_DESER_PARITY_EN to receive and check one trailing parity bit per word.
module sreg_deser #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned LSB_FIRST  = 1,
  parameter int unsigned PARITY_ODD = 0,
  localparam int unsigned CW        = $clog2(WIDTH + 2)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Ena,
  input  logic             Din,
  input  logic             Clear,
  output logic [WIDTH-1:0] Qout,
  output logic             Qvalid,
  input  logic             Qready,
  output logic             Overrun,
  input  logic             OvrClr,
  output logic             Perr,
  output logic [CW-1:0]    Count
);

`ifdef SREG_DESER_PARITY_EN
  localparam int unsigned N = WIDTH + 1;
`else
  localparam int unsigned N = WIDTH;
`endif
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (WIDTH < 2 || PARITY_ODD > 1) begin : g_cfg_check
    $error("sreg_deser: WIDTH must be >= 2 and PARITY_ODD must be 0 or 1");
  end

  logic [WIDTH-1:0] sreg_q, sreg_d, shifted, sreg_step, word;
  logic [WIDTH-1:0] qout_q, qout_d;
  logic [CW-1:0]    count_q, count_d;
  logic             qvalid_q, qvalid_d;
  logic             ovr_q, ovr_d;
  logic             done, accept;

  always_comb begin
    shifted = (LSB_FIRST != 0) ? {Din, sreg_q[WIDTH-1:1]} : {sreg_q[WIDTH-2:0], Din};
    done    = Ena && !Clear && (count_q == LAST);
`ifdef SREG_DESER_PARITY_EN
    // The final bit is parity: it completes the word but is never shifted into the data.
    word      = sreg_q;
    sreg_step = (count_q == LAST) ? sreg_q : shifted;
`else
    word      = shifted;
    sreg_step = shifted;
`endif
    accept = done && (!qvalid_q || Qready);

    sreg_d  = sreg_q;
    count_d = count_q;
    if (Clear) begin
      sreg_d  = '0;
      count_d = '0;
    end else if (Ena) begin
      sreg_d  = sreg_step;
      count_d = done ? '0 : count_q + CW'(1);
    end

    qout_d   = accept ? word : qout_q;
    qvalid_d = accept ? 1'b1 : (Qready ? 1'b0 : qvalid_q);
    ovr_d    = (done && qvalid_q && !Qready) ? 1'b1 : (OvrClr ? 1'b0 : ovr_q);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      sreg_q   <= '0;
      count_q  <= '0;
      qout_q   <= '0;
      qvalid_q <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      sreg_q   <= sreg_d;
      count_q  <= count_d;
      qout_q   <= qout_d;
      qvalid_q <= qvalid_d;
      ovr_q    <= ovr_d;
    end
  end

`ifdef SREG_DESER_PARITY_EN
  logic perr_q, perr_d;

  always_comb begin
    perr_d = perr_q;
    if (accept) perr_d = ((^sreg_q) ^ Din) != (PARITY_ODD != 0);
  end

  always_ff @(posedge Clk) begin
    if (Rst) perr_q <= 1'b0;
    else     perr_q <= perr_d;
  end

  assign Perr = perr_q;
`else
  assign Perr = 1'b0;
`endif

  assign Qout    = qout_q;
  assign Qvalid  = qvalid_q;
  assign Overrun = ovr_q;
  assign Count   = count_q;

endmodule

// File: tb/tb_sreg_deser.sv
// Bench for sreg_deser: LSB-first and MSB-first instances share stimulus and are checked
// against a bit-queue reference model; directed cases first, then randomized traffic.
module tb_sreg_deser;
  localparam int unsigned W  = 8;
  localparam int unsigned CW = $clog2(W + 2);
`ifdef SREG_DESER_PARITY_EN
  localparam int unsigned N = W + 1;
`else
  localparam int unsigned N = W;
`endif

  logic Clk = 1'b0;
  logic Rst, Ena, Din, Clear, Qready, OvrClr;
  logic [W-1:0]  q_l, q_m;
  logic          v_l, v_m, o_l, o_m, p_l, p_m;
  logic [CW-1:0] c_l, c_m;

  int nchecks = 0;
  int nerr    = 0;

  // reference model state
  bit          mbits[$];
  logic [W-1:0] m_ql, m_qm;
  logic        m_valid, m_ovr, m_perr;

  always #5 Clk = ~Clk;

  sreg_deser #(.WIDTH(W), .LSB_FIRST(1), .PARITY_ODD(0)) u_lsb (
    .Clk(Clk), .Rst(Rst), .Ena(Ena), .Din(Din), .Clear(Clear),
    .Qout(q_l), .Qvalid(v_l), .Qready(Qready), .Overrun(o_l),
    .OvrClr(OvrClr), .Perr(p_l), .Count(c_l));

  sreg_deser #(.WIDTH(W), .LSB_FIRST(0), .PARITY_ODD(0)) u_msb (
    .Clk(Clk), .Rst(Rst), .Ena(Ena), .Din(Din), .Clear(Clear),
    .Qout(q_m), .Qvalid(v_m), .Qready(Qready), .Overrun(o_m),
    .OvrClr(OvrClr), .Perr(p_m), .Count(c_m));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_update(input logic rst, ena, din, clr, rdy, oc);
    bit           done;
    int           ones;
    logic [W-1:0] wl, wm;
    logic         pe, was_valid;
    done = 1'b0;
    if (rst) begin
      mbits.delete();
      m_ql = '0; m_qm = '0; m_valid = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
      return;
    end
    if (clr) mbits.delete();
    else if (ena) begin
      mbits.push_back(din);
      if (mbits.size() == N) begin
        done = 1'b1;
        ones = 0;
        for (int i = 0; i < W; i++) begin
          wl[i]       = mbits[i];
          wm[W-1-i]   = mbits[i];
          ones       += int'(mbits[i]);
        end
`ifdef SREG_DESER_PARITY_EN
        pe = ((ones + int'(mbits[W])) % 2) != 0;
`else
        pe = 1'b0;
`endif
        mbits.delete();
      end
    end
    was_valid = m_valid;
    if (done && (!was_valid || rdy)) begin
      m_ql = wl; m_qm = wm; m_perr = pe; m_valid = 1'b1;
    end else if (was_valid && rdy) m_valid = 1'b0;
    if (done && was_valid && !rdy) m_ovr = 1'b1;
    else if (oc) m_ovr = 1'b0;
  endtask

  task automatic step(input logic rst, ena, din, clr, rdy, oc);
    Rst = rst; Ena = ena; Din = din; Clear = clr; Qready = rdy; OvrClr = oc;
    @(posedge Clk);
    model_update(rst, ena, din, clr, rdy, oc);
    #1;
    chk("qout_lsb", 32'(q_l), 32'(m_ql));
    chk("qout_msb", 32'(q_m), 32'(m_qm));
    chk("qvalid_lsb", 32'(v_l), 32'(m_valid));
    chk("qvalid_msb", 32'(v_m), 32'(m_valid));
    chk("overrun_lsb", 32'(o_l), 32'(m_ovr));
    chk("overrun_msb", 32'(o_m), 32'(m_ovr));
    chk("perr_lsb", 32'(p_l), 32'(m_perr));
    chk("perr_msb", 32'(p_m), 32'(m_perr));
    chk("count_lsb", 32'(c_l), 32'(mbits.size()));
    chk("count_msb", 32'(c_m), 32'(mbits.size()));
  endtask

  // Sends byte b first bit b[0]; parity bit (if any) is b's even parity xor flip.
  task automatic send_word(input logic [W-1:0] b, input logic rdy_last, input logic flip);
    for (int i = 0; i < N; i++) begin
      logic bt;
      bt = (i < W) ? b[i] : ((^b) ^ flip);
      step(1'b0, 1'b1, bt, 1'b0, (i == N - 1) ? rdy_last : 1'b0, 1'b0);
    end
  endtask

  initial begin
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("reset_qvalid", 32'(v_l), 32'd0);
    chk("reset_count", 32'(c_l), 32'd0);

    // stream 1,0,1,1,0,0,1,0
    send_word(8'h4D, 1'b0, 1'b0);
    chk("t1_qout_lsb", 32'(q_l), 32'h4D);
    chk("t2_qout_msb", 32'(q_m), 32'hB2);
    chk("t1_qvalid", 32'(v_l), 32'd1);
    chk("t1_count", 32'(c_l), 32'd0);
    chk("t6_perr_even_ok", 32'(p_l), 32'd0);

    // second word while full -> dropped, overrun
    send_word(8'hA7, 1'b0, 1'b0);
    chk("t3_qout_kept", 32'(q_l), 32'h4D);
    chk("t3_overrun", 32'(o_l), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t3_ovrclr", 32'(o_l), 32'd0);

    // drain on the completion edge of the next word
    send_word(8'h96, 1'b1, 1'b0);
    chk("t4_qout_new", 32'(q_l), 32'h96);
    chk("t4_qvalid_stays", 32'(v_l), 32'd1);
    chk("t4_no_overrun", 32'(o_l), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("drain_qvalid", 32'(v_l), 32'd0);
    chk("drain_qout_held", 32'(q_l), 32'h96);

    // clear after 5 bits; Clear+Ena bit dropped
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("t5_clear_count", 32'(c_l), 32'd0);
    send_word(8'h3C, 1'b0, 1'b0);
    chk("t5_qout", 32'(q_l), 32'h3C);

`ifdef SREG_DESER_PARITY_EN
    send_word(8'h4D, 1'b1, 1'b1);
    chk("t6_perr_bad", 32'(p_l), 32'd1);
    chk("t6_qout", 32'(q_l), 32'h4D);
`endif

    // overrun set wins over OvrClr on the same edge
    for (int i = 0; i < N; i++)
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, (i == N - 1) ? 1'b1 : 1'b0);
    chk("ovr_set_wins", 32'(o_l), 32'd1);

    for (int n = 0; n < 2000; n++) begin
      step(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
           1'($urandom),
           ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 1) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end
endmodule
